// File: rtl/sample_playback_ctrl_if.sv
// Memory read port and DAC valid/ready port of the sample playback sequencer.
// master = sequencer side, slave = memory/DAC side.
interface sample_playback_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 12
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] dac_data;
    logic              dac_valid;
    logic              dac_ready;

    modport master (
        output mem_rd, mem_addr, dac_data, dac_valid,
        input  mem_data, dac_ready
    );

    modport slave (
        input  mem_rd, mem_addr, dac_data, dac_valid,
        output mem_data, dac_ready
    );
endinterface

// File: rtl/sample_playback_ctrl.sv
// Sample-table playback sequencer: rate prescaler, table address walk, 1-cycle memory
// reads and DAC handshake. Optional PLAYBACK_START_ADDR_EN adds a start/wrap address input.
module sample_playback_ctrl #(
    parameter  int SIZE   = 12,
    parameter  int DATA_W = 12,
    parameter  int DIV_W  = 16,
    localparam int ADDR_W = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic                  clk,
    input  logic                  need_reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  oneshot,
    input  logic [DIV_W-1:0]      div,
`ifdef PLAYBACK_START_ADDR_EN
    input  logic [ADDR_W-1:0]     start_addr,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  miss,
    sample_playback_ctrl_if.master bus
);

    typedef enum logic [1:0] {IDLE, WAIT, FETCH, HOLD} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(SIZE - 1);

    state_t            state;
    logic [DIV_W-1:0]  presc;
    logic [DIV_W-1:0]  div_l;
    logic              oneshot_l;
    logic [ADDR_W-1:0] start_l;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] sample;
    logic              valid;
    logic              stop_pend;
    logic              tick;

`ifdef PLAYBACK_START_ADDR_EN
    logic [ADDR_W-1:0] start_a;
    // Out-of-range start addresses fall back to the table base
    assign start_a = (int'(start_addr) >= SIZE) ? '0 : start_addr;
`else
    localparam logic [ADDR_W-1:0] start_a = '0;
`endif

    assign tick          = (state != IDLE) && (presc == div_l);
    // Read is issued in the tick cycle so the sample lands in FETCH one clock later
    assign bus.mem_rd    = (state == WAIT) && tick && !stop;
    assign bus.mem_addr  = addr;
    assign bus.dac_data  = sample;
    assign bus.dac_valid = valid;
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or posedge need_reset) begin
        if (need_reset) begin
            state     <= IDLE;
            presc     <= '0;
            div_l     <= '0;
            oneshot_l <= 1'b0;
            start_l   <= '0;
            addr      <= '0;
            sample    <= '0;
            valid     <= 1'b0;
            stop_pend <= 1'b0;
            done      <= 1'b0;
            miss      <= 1'b0;
        end else begin
            done <= 1'b0;
            miss <= 1'b0;
            if (state != IDLE)
                presc <= (presc == div_l) ? '0 : presc + 1'b1;

            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        div_l     <= div;
                        oneshot_l <= oneshot;
                        start_l   <= start_a;
                        addr      <= start_a;
                        presc     <= '0;
                        stop_pend <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (stop) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (tick) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    sample <= bus.mem_data;
                    valid  <= 1'b1;
                    state  <= HOLD;
                    if (tick) miss      <= 1'b1;
                    if (stop) stop_pend <= 1'b1;
                end
                HOLD: begin
                    // A tick here is dropped even if the transfer completes this cycle
                    if (tick) miss      <= 1'b1;
                    if (stop) stop_pend <= 1'b1;
                    if (bus.dac_ready) begin
                        valid <= 1'b0;
                        if (stop_pend || stop) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else if (addr == LAST) begin
                            if (oneshot_l) begin
                                done  <= 1'b1;
                                state <= IDLE;
                            end else begin
                                addr  <= start_l;
                                state <= WAIT;
                            end
                        end else begin
                            addr  <= addr + 1'b1;
                            state <= WAIT;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sample_playback_ctrl.sv
// Directed bench for sample_playback_ctrl with a synchronous table memory model.
module tb_sample_playback_ctrl;

    localparam int SIZE = 12, DATA_W = 12, DIV_W = 16, ADDR_W = 4;

    logic clk = 1'b0;
    logic need_reset, start, stop, oneshot;
    logic [DIV_W-1:0] div;
    logic busy, done, miss;
`ifdef PLAYBACK_START_ADDR_EN
    logic [ADDR_W-1:0] start_addr;
`endif

    sample_playback_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sample_playback_ctrl #(.SIZE(SIZE), .DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
        .clk        (clk),
        .need_reset (need_reset),
        .start      (start),
        .stop       (stop),
        .oneshot    (oneshot),
        .div        (div),
`ifdef PLAYBACK_START_ADDR_EN
        .start_addr (start_addr),
`endif
        .busy       (busy),
        .done       (done),
        .miss       (miss),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] tbl(input int a);
        return 12'h300 + 12'(a * 17);
    endfunction

    // Table memory: data valid the cycle after mem_rd
    always @(posedge clk) if (bus.mem_rd) bus.mem_data <= tbl(int'(bus.mem_addr));

    int cyc = 0, miss_cnt = 0, done_cnt = 0;
    int rd_cyc[$], rd_addr[$], xfer[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (miss) miss_cnt <= miss_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (bus.mem_rd) begin
            rd_cyc.push_back(cyc);
            rd_addr.push_back(int'(bus.mem_addr));
        end
        if (bus.dac_valid && bus.dac_ready) xfer.push_back(int'(bus.dac_data));
    end

    int errors = 0, checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic os, input int d);
        oneshot = os;
        div     = DIV_W'(d);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!bus.dac_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid_timeout"}, bus.dac_valid, 1);
    endtask

    task automatic wait_done(input string tag);
        int b = done_cnt;
        int n = 0;
        while (done_cnt == b && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_timeout"}, done_cnt - b, 1);
    endtask

    task automatic wait_rds(input string tag, input int target);
        int n = 0;
        while (rd_addr.size() < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rd_timeout"}, rd_addr.size() >= target, 1);
    endtask

    initial begin
        int st, rb, xb, mb, db, vc;
        need_reset = 1'b1; start = 1'b0; stop = 1'b0; oneshot = 1'b0; div = '0;
        bus.dac_ready = 1'b0;
`ifdef PLAYBACK_START_ADDR_EN
        start_addr = '0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_mem_rd", bus.mem_rd, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_dac_valid", bus.dac_valid, 0);
        chk("rst_dac_data", bus.dac_data, 0);
        chk("rst_done_miss", {done, miss}, 0);
        need_reset = 1'b0;
        @(negedge clk);

        // Loop, div=3, always ready: read every 4 clocks, addrs wrap 11 -> 0
        bus.dac_ready = 1'b1;
        rb = rd_addr.size(); xb = xfer.size(); mb = miss_cnt;
        oneshot = 1'b0; div = 16'd3;
        @(negedge clk);
        st = cyc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid("loop");
        vc = cyc;
        wait_rds("loop", rb + 14);
        chk("loop_first_rd_cyc", rd_cyc[rb] - st, 4);
        chk("loop_first_valid_cyc", vc - st, 6);
        for (int i = 0; i < 14; i++) begin
            chk($sformatf("loop_addr%0d", i), rd_addr[rb+i], i % SIZE);
            if (i > 0) chk($sformatf("loop_period%0d", i), rd_cyc[rb+i] - rd_cyc[rb+i-1], 4);
        end
        for (int i = 0; i < SIZE; i++)
            chk($sformatf("loop_data%0d", i), xfer[xb+i], tbl(i));
        chk("loop_no_miss", miss_cnt - mb, 0);
        pulse_stop();
        wait_done("loop_stop");
        chk("loop_idle", busy, 0);

        // Oneshot, div=0: 12 transfers then done; every FETCH and HOLD tick is dropped
        xb = xfer.size(); mb = miss_cnt; db = done_cnt;
        go(1'b1, 0);
        wait_done("os");
        repeat (3) @(negedge clk);
        chk("os_xfers", xfer.size() - xb, SIZE);
        for (int i = 0; i < SIZE; i++)
            chk($sformatf("os_data%0d", i), xfer[xb+i], tbl(i));
        chk("os_done_once", done_cnt - db, 1);
        chk("os_miss", miss_cnt - mb, 24);
        chk("os_idle", busy, 0);

        // div=1, DAC stalls 6 clocks on the first sample
        bus.dac_ready = 1'b0;
        rb = rd_addr.size();
        go(1'b0, 1);
        wait_valid("stall");
        mb = miss_cnt;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("stall_hold%0d", i), {bus.dac_valid, bus.dac_data}, {1'b1, tbl(0)});
        end
        chk("stall_miss", miss_cnt - mb, 3);
        chk("stall_one_rd", rd_addr.size() - rb, 1);
        bus.dac_ready = 1'b1;
        wait_rds("stall", rb + 2);
        chk("stall_next_addr", rd_addr[rb+1], 1);
        pulse_stop();
        wait_done("stall_stop");

        // stop during HOLD with DAC not ready
        bus.dac_ready = 1'b0;
        go(1'b0, 3);
        wait_valid("hstop");
        pulse_stop();
        rb = rd_addr.size();
        repeat (3) @(negedge clk);
        chk("hstop_kept", {busy, bus.dac_valid, bus.dac_data}, {1'b1, 1'b1, tbl(0)});
        bus.dac_ready = 1'b1;
        wait_done("hstop");
        chk("hstop_idle", {busy, bus.dac_valid}, 0);
        repeat (6) @(negedge clk);
        chk("hstop_no_rd", rd_addr.size() - rb, 0);

        // Async reset mid-HOLD
        bus.dac_ready = 1'b0;
        go(1'b0, 3);
        wait_valid("arst");
        db = done_cnt;
        #2 need_reset = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_dac", {bus.dac_valid, bus.dac_data}, 0);
        chk("arst_addr_rd", {bus.mem_addr, bus.mem_rd}, 0);
        @(negedge clk);
        need_reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("arst_no_done", done_cnt - db, 0);
        chk("arst_still_idle", busy, 0);

        // start and stop together in IDLE: stop wins
        rb = rd_addr.size();
        @(negedge clk);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        repeat (4) @(negedge clk);
        chk("ss_idle", busy, 0);
        chk("ss_no_rd", rd_addr.size() - rb, 0);

`ifdef PLAYBACK_START_ADDR_EN
        bus.dac_ready = 1'b1;
        start_addr = 4'd10;
        rb = rd_addr.size();
        go(1'b0, 0);
        wait_rds("sa10", rb + 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("sa10_addr%0d", i), rd_addr[rb+i], 10 + (i % 2));
        pulse_stop();
        wait_done("sa10");
        start_addr = 4'd15;
        rb = rd_addr.size();
        go(1'b0, 0);
        wait_rds("sa15", rb + 2);
        chk("sa15_addr0", rd_addr[rb], 0);
        chk("sa15_addr1", rd_addr[rb+1], 1);
        pulse_stop();
        wait_done("sa15");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
